sum_accum: RTL and testbench

- Downstream consumer of the registered 4-bit adder stage (`sum` 5-bit, `overflow` 1-bit).
- Accumulates a window of WIN adder results into a wider saturating accumulator.
- Counts how many accepted samples carried the adder overflow flag.
- Presents each window result through a valid/ready output handshake, so a monitor or CPU-side reader can drain it at its own pace.

---
 rtl/sum_accum.sv | 153 +++++++++++++++
 tb/tb_sum_accum.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sum_accum.sv
// Windowed saturating accumulator for the registered adder stage. Each window of up to WIN
// accepted samples is summed, its overflow flags are counted, and the result is offered
// downstream through a valid/ready handshake.
module sum_accum #(
  parameter int unsigned IN_W  = 5,
  parameter int unsigned ACC_W = 8,
  parameter int unsigned WIN   = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  sum_in,
  input  logic             ovf_in,
  input  logic             flush,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             sat_out,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] smp_cnt
);

  localparam logic [CNT_W-1:0] WinCnt = CNT_W'(WIN);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [ACC_W-1:0] AccMax = {ACC_W{1'b1}};

  typedef enum logic [0:0] {StAcc, StHold} state_e;

  state_e           state_q, state_d;
  logic             run_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ovc_q, ovc_d;
  logic             sat_q, sat_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic             sat_out_q, sat_out_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;

  logic             accept;
  logic             close;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] acc_new;
  logic             sat_new;
  logic [CNT_W-1:0] cnt_new;
  logic [CNT_W-1:0] ovc_new;

  // run_q keeps in_ready low until the first edge after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StAcc;
      run_q     <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovc_q     <= '0;
      sat_q     <= 1'b0;
      acc_out_q <= '0;
      sat_out_q <= 1'b0;
      ovf_cnt_q <= '0;
      smp_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovc_q     <= ovc_d;
      sat_q     <= sat_d;
      acc_out_q <= acc_out_d;
      sat_out_q <= sat_out_d;
      ovf_cnt_q <= ovf_cnt_d;
      smp_cnt_q <= smp_cnt_d;
    end
  end

  // Window datapath: values after including this cycle's sample (if any), and the close decision.
  always_comb begin
    accept  = in_valid & in_ready;
    sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, sum_in};
    acc_new = acc_q;
    sat_new = sat_q;
    cnt_new = cnt_q;
    ovc_new = ovc_q;
    if (accept) begin
      if (sum_ext[ACC_W]) begin
        acc_new = AccMax;
        sat_new = 1'b1;
      end else begin
        acc_new = sum_ext[ACC_W-1:0];
      end
      cnt_new = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
      if (ovf_in) begin
        ovc_new = (ovc_q == CntMax) ? ovc_q : ovc_q + 1'b1;
      end
    end
    close = (state_q == StAcc) && !clr &&
            ((accept && (cnt_new == WinCnt)) || (flush && (cnt_new != '0)));
  end

  // Next-state: window state, result capture and handshake.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovc_d     = ovc_q;
    sat_d     = sat_q;
    acc_out_d = acc_out_q;
    sat_out_d = sat_out_q;
    ovf_cnt_d = ovf_cnt_q;
    smp_cnt_d = smp_cnt_q;
    unique case (state_q)
      StAcc: begin
        if (clr || close) begin
          acc_d = '0;
          cnt_d = '0;
          ovc_d = '0;
          sat_d = 1'b0;
        end else begin
          acc_d = acc_new;
          cnt_d = cnt_new;
          ovc_d = ovc_new;
          sat_d = sat_new;
        end
        if (close) begin
          acc_out_d = acc_new;
          sat_out_d = sat_new;
          ovf_cnt_d = ovc_new;
          smp_cnt_d = cnt_new;
          state_d   = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StAcc;
        end
      end
      default: state_d = StAcc;
    endcase
  end

  // Outputs: ready/valid decoded from state, results straight from the capture registers.
  always_comb begin
    in_ready  = (state_q == StAcc) && run_q;
    out_valid = (state_q == StHold);
    acc_out   = acc_out_q;
    sat_out   = sat_out_q;
    ovf_cnt   = ovf_cnt_q;
    smp_cnt   = smp_cnt_q;
  end

endmodule

// File: tb/tb_sum_accum.sv
module tb_sum_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, ovf_in, flush, clr, out_valid, out_ready;
  logic [4:0] sum_in;
  logic [7:0] acc_out;
  logic       sat_out;
  logic [3:0] ovf_cnt, smp_cnt;
  logic       in_ready6, out_valid6, sat_out6;
  logic [5:0] acc_out6;
  logic [3:0] ovf_cnt6, smp_cnt6;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sum_accum dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sum_in(sum_in),
    .ovf_in(ovf_in), .flush(flush), .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .sat_out(sat_out), .ovf_cnt(ovf_cnt), .smp_cnt(smp_cnt)
  );

  // Narrow accumulator instance sharing the same stimulus, for saturation corners.
  sum_accum #(.ACC_W(6)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready6), .sum_in(sum_in),
    .ovf_in(ovf_in), .flush(flush), .clr(clr), .out_valid(out_valid6), .out_ready(out_ready),
    .acc_out(acc_out6), .sat_out(sat_out6), .ovf_cnt(ovf_cnt6), .smp_cnt(smp_cnt6)
  );

  typedef struct {
    logic       vld;
    logic [4:0] sum;
    logic       ovf, fl, cl;
    bit         push;
    int         hold;
    logic [7:0] acc;
    logic       sat;
    logic [3:0] ovc, smp;
    logic [5:0] acc6;
    logic       sat6;
  } vec_t;

  typedef struct {
    logic [7:0] acc;
    logic       sat;
    logic [3:0] ovc, smp;
    logic [5:0] acc6;
    logic       sat6;
  } res_t;

  res_t sb[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic vld, input logic [4:0] sum, input logic ovf,
                              input logic fl, input logic cl, input bit push = 0,
                              input int hold = 0, input logic [7:0] acc = 0,
                              input logic sat = 0, input logic [3:0] ovc = 0,
                              input logic [3:0] smp = 0, input logic [5:0] acc6 = 0,
                              input logic sat6 = 0);
    vec_t v;
    v.vld = vld; v.sum = sum; v.ovf = ovf; v.fl = fl; v.cl = cl; v.push = push;
    v.hold = hold; v.acc = acc; v.sat = sat; v.ovc = ovc; v.smp = smp;
    v.acc6 = acc6; v.sat6 = sat6;
    return v;
  endfunction

  // Drive one vector for a cycle; on a window close, compare against the scoreboard,
  // optionally stall the reader, then complete the handshake.
  task automatic drive(input vec_t v);
    res_t e, r;
    in_valid = v.vld; sum_in = v.sum; ovf_in = v.ovf; flush = v.fl; clr = v.cl;
    if (v.push) begin
      e.acc = v.acc; e.sat = v.sat; e.ovc = v.ovc; e.smp = v.smp;
      e.acc6 = v.acc6; e.sat6 = v.sat6;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 0; flush = 0; clr = 0; ovf_in = 0;
    check("out_valid", out_valid, v.push);
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard: out_valid with no expected result");
      end else begin
        r = sb.pop_front();
        check("acc_out", acc_out, r.acc);
        check("sat_out", sat_out, r.sat);
        check("ovf_cnt", ovf_cnt, r.ovc);
        check("smp_cnt", smp_cnt, r.smp);
        check("acc_out6", acc_out6, r.acc6);
        check("sat_out6", sat_out6, r.sat6);
        for (int i = 0; i < v.hold; i++) begin
          in_valid = 1; sum_in = 5'd31; ovf_in = 1;
          @(posedge clk); #1;
          check("hold_valid", out_valid, 1'b1);
          check("hold_in_ready", in_ready, 1'b0);
          check("hold_acc", acc_out, r.acc);
          check("hold_ovc", ovf_cnt, r.ovc);
        end
      end
      in_valid = 0; ovf_in = 0;
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      check("hs_out_valid", out_valid, 1'b0);
      check("hs_in_ready", in_ready, 1'b1);
    end
  endtask

  initial begin
    rst = 1; in_valid = 0; sum_in = 0; ovf_in = 0; flush = 0; clr = 0; out_ready = 0;

    // Basic window with stalled reader; dropped samples must not leak into the next window.
    vecs.push_back(mk(1, 30, 1, 0, 0));
    vecs.push_back(mk(1, 6, 0, 0, 0));
    vecs.push_back(mk(1, 24, 1, 0, 0));
    vecs.push_back(mk(1, 18, 1, 0, 0, 1, 5, 8'd78, 0, 3, 4, 6'd63, 1));
    // Saturation on the narrow instance, then a clean window.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 31, 0, 0, 0));
    vecs.push_back(mk(1, 31, 0, 0, 0, 1, 0, 8'd124, 0, 0, 4, 6'd63, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 8'd4, 0, 0, 4, 6'd4, 0));
    // Flush with accept, then flush on an empty window.
    vecs.push_back(mk(1, 5, 0, 0, 0));
    vecs.push_back(mk(1, 7, 1, 0, 0));
    vecs.push_back(mk(1, 9, 0, 1, 0, 1, 0, 8'd21, 0, 1, 3, 6'd21, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0));
    // clr beats accept and flush.
    vecs.push_back(mk(1, 10, 1, 0, 0));
    vecs.push_back(mk(1, 10, 1, 0, 0));
    vecs.push_back(mk(1, 3, 1, 1, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 2, 0, 0, 0));
    vecs.push_back(mk(1, 2, 0, 0, 0, 1, 0, 8'd8, 0, 0, 4, 6'd8, 0));

    #2;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_acc_out", acc_out, 8'd0);
    @(posedge clk); #1; rst = 0;
    check("rel_in_ready_before", in_ready, 1'b0);
    @(posedge clk); #1;
    check("rel_in_ready_after", in_ready, 1'b1);

    foreach (vecs[i]) drive(vecs[i]);

    // Reset mid-window: pending partial and last result are wiped immediately.
    drive(mk(1, 3, 1, 0, 0));
    drive(mk(1, 4, 0, 0, 0));
    rst = 1; #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_acc_out", acc_out, 8'd0);
    check("mid_rst_smp_cnt", smp_cnt, 4'd0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1; rst = 0;
    check("mid_rel_in_ready_before", in_ready, 1'b0);
    @(posedge clk); #1;
    check("mid_rel_in_ready_after", in_ready, 1'b1);
    drive(mk(1, 2, 1, 0, 0));
    drive(mk(1, 2, 0, 0, 0));
    drive(mk(1, 2, 0, 0, 0));
    drive(mk(1, 2, 0, 0, 0, 1, 0, 8'd8, 0, 1, 4, 6'd8, 0));

    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
